// File: rtl/apb_pkg.sv
// Shared types and command encodings for the single-channel APB requester.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

endpackage

// File: rtl/apb_master.sv
// APB requester: a read captures data from a fixed address, a write sends
// back (last read data + 1) to the same address.
//
// state  | meaning
// IDLE   | bus idle, psel low, waiting for a read/write command
// SETUP  | psel high, address/control/data presented for one cycle
// ACCESS | psel and penable high, held until the completer raises pready
module apb_master
    import apb_pkg::*;
#(
    parameter int              AW   = 32,
    parameter int              DW   = 32,
    parameter logic [AW-1:0]   ADDR = 32'hDEAD_CAFE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cmd_i,
    output logic          psel_o,
    output logic          penable_o,
    output logic [AW-1:0] paddr_o,
    output logic          pwrite_o,
    output logic [DW-1:0] pwdata_o,
    input  logic          pready_i,
    input  logic [DW-1:0] prdata_i
);

    apb_state_t    state;
    apb_state_t    state_nxt;
    logic          start;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_i == CMD_READ || cmd_i == CMD_WRITE) begin
                    start     = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer attributes are latched only when a command is accepted, so
    // they stay stable through SETUP and ACCESS regardless of cmd_i.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            rdata_q  <= '0;
        end else begin
            if (start) begin
                pwrite_o <= (cmd_i == CMD_WRITE);
                paddr_o  <= ADDR;
                pwdata_o <= rdata_q + DW'(1);
            end
            if (state == ACCESS && pready_i && !pwrite_o) begin
                rdata_q <= prdata_i;
            end
        end
    end

    assign psel_o    = (state != IDLE);
    assign penable_o = (state == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: scoreboard of expected transfers
// checked at each completed access, plus per-phase bus checks.
module tb_apb_master;
    import apb_pkg::*;

    localparam logic [31:0] ADDR = 32'hDEAD_CAFE;

    logic        clk;
    logic        reset;
    logic [1:0]  cmd_i;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_rd = 32'h0;

    apb_master #(.AW(32), .DW(32), .ADDR(ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_i     (cmd_i),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .paddr_o   (paddr_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pready_i  (pready_i),
        .prdata_i  (prdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every completed access must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && psel_o && penable_o && pready_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                xfer_t e;
                e = sb_q.pop_front();
                chk("sb_pwrite", {31'd0, pwrite_o}, {31'd0, e.wr});
                chk("sb_paddr", paddr_o, e.addr);
                if (e.wr) chk("sb_pwdata", pwdata_o, e.wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic en,
                             input logic wr, input logic [31:0] wd);
        chk({tag, "_psel"}, {31'd0, psel_o}, {31'd0, sel});
        chk({tag, "_penable"}, {31'd0, penable_o}, {31'd0, en});
        chk({tag, "_pwrite"}, {31'd0, pwrite_o}, {31'd0, wr});
        chk({tag, "_paddr"}, paddr_o, ADDR);
        if (wr) chk({tag, "_pwdata"}, pwdata_o, wd);
    endtask

    // Called #1 after a posedge with the DUT in IDLE. waits = low-pready
    // ACCESS cycles before completion; hold keeps the command asserted.
    task automatic xfer(input logic wr, input int waits, input logic [31:0] rd,
                        input logic hold);
        xfer_t       e;
        logic [31:0] wd;
        wd      = model_rd + 32'd1;
        e.wr    = wr;
        e.addr  = ADDR;
        e.wdata = wd;
        sb_q.push_back(e);
        cmd_i    = wr ? CMD_WRITE : CMD_READ;
        pready_i = 1'b0;
        @(negedge clk);
        chk("idle_psel", {31'd0, psel_o}, 32'd0);
        cyc();
        if (!hold) cmd_i = CMD_NOP;
        pready_i = 1'b1;
        prdata_i = $urandom;
        @(negedge clk);
        check_bus("setup", 1'b1, 1'b0, wr, wd);
        for (int n = 0; n <= waits; n++) begin
            cyc();
            pready_i = (n == waits);
            prdata_i = (n == waits) ? rd : $urandom;
            @(negedge clk);
            check_bus("access", 1'b1, 1'b1, wr, wd);
        end
        cyc();
        pready_i = 1'b0;
        if (!wr) model_rd = rd;
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        cmd_i    = CMD_READ;
        pready_i = 1'b0;
        prdata_i = 32'h0;

        // Reset held two cycles with a read command pending.
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_psel", {31'd0, psel_o}, 32'd0);
        chk("rst_penable", {31'd0, penable_o}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite_o}, 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        chk("rst_pwdata", pwdata_o, 32'd0);
        cyc();
        reset = 1'b0;
        cmd_i = CMD_NOP;
        @(negedge clk);
        chk("post_rst_psel", {31'd0, psel_o}, 32'd0);
        cyc();

        // Basic read, then write with wait states, then a second write.
        xfer(1'b0, 0, 32'h5, 1'b0);
        xfer(1'b1, 3, 32'h0, 1'b0);
        xfer(1'b1, 0, 32'h0, 1'b0);

        // Reserved and no-op commands never select the completer.
        for (int i = 0; i < 10; i++) begin
            cmd_i = (i < 5) ? CMD_RSVD : CMD_NOP;
            @(negedge clk);
            chk("nop_psel", {31'd0, psel_o}, 32'd0);
            cyc();
        end

        // Held read: one IDLE cycle between back-to-back transfers.
        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, int'($urandom_range(0, 9)), $urandom, (i != 4));
        end
        xfer(1'b1, 1, 32'h0, 1'b0);

        // Reset in the middle of an ACCESS phase.
        cmd_i    = CMD_READ;
        pready_i = 1'b0;
        cyc();
        cmd_i = CMD_NOP;
        cyc();
        @(negedge clk);
        chk("mid_penable", {31'd0, penable_o}, 32'd1);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_pre_rst_psel", {31'd0, psel_o}, 32'd1);
        cyc();
        reset = 1'b0;
        sb_q.delete();
        model_rd = 32'h0;
        @(negedge clk);
        chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
        chk("mid_rst_penable", {31'd0, penable_o}, 32'd0);
        chk("mid_rst_pwrite", {31'd0, pwrite_o}, 32'd0);
        chk("mid_rst_paddr", paddr_o, 32'd0);
        chk("mid_rst_pwdata", pwdata_o, 32'd0);
        cyc();

        // rdata cleared by reset, then wrap of all-ones read data.
        xfer(1'b1, 0, 32'h0, 1'b0);
        xfer(1'b0, 2, 32'hFFFF_FFFF, 1'b0);
        xfer(1'b1, 0, 32'h0, 1'b0);

        chk("final_queue", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
